// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bundle: decoded ID fields, EX/MEM and MEM/WB forwarding
// sources, ALU zero flag in; ALU operands, EX controls, stall and flush out.
interface ex_operand_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_ReadData1;
  logic [DATA_W-1:0] id_ReadData2;
  logic [DATA_W-1:0] id_Imm;
  logic [REG_AW-1:0] id_Rs;
  logic [REG_AW-1:0] id_Rt;
  logic [REG_AW-1:0] id_Rd;
  logic              id_ALUSrc;
  logic              id_RegDst;
  logic              id_MemRead;
  logic              id_MemWrite;
  logic              id_RegWrite;
  logic              id_MemtoReg;
  logic              id_Branch;
  logic [3:0]        id_ALU_control;

  logic              mem_RegWrite;
  logic [REG_AW-1:0] mem_WriteReg;
  logic [DATA_W-1:0] mem_ALU_result;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_WriteReg;
  logic [DATA_W-1:0] wb_WriteData;
  logic              ZeroFlag;

  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [3:0]        ALU_control;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_StoreData;
  logic [REG_AW-1:0] ex_WriteReg;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_RegWrite;
  logic              ex_MemtoReg;
  logic              stall;
  logic              flush;

  modport master (
    output id_valid, id_ReadData1, id_ReadData2, id_Imm, id_Rs, id_Rt, id_Rd,
           id_ALUSrc, id_RegDst, id_MemRead, id_MemWrite, id_RegWrite,
           id_MemtoReg, id_Branch, id_ALU_control,
           mem_RegWrite, mem_WriteReg, mem_ALU_result,
           wb_RegWrite, wb_WriteReg, wb_WriteData, ZeroFlag,
    input  ReadData1, ReadData2, ALU_control, ex_valid, ex_StoreData,
           ex_WriteReg, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
           stall, flush
  );

  modport slave (
    input  id_valid, id_ReadData1, id_ReadData2, id_Imm, id_Rs, id_Rt, id_Rd,
           id_ALUSrc, id_RegDst, id_MemRead, id_MemWrite, id_RegWrite,
           id_MemtoReg, id_Branch, id_ALU_control,
           mem_RegWrite, mem_WriteReg, mem_ALU_result,
           wb_RegWrite, wb_WriteReg, wb_WriteData, ZeroFlag,
    output ReadData1, ReadData2, ALU_control, ex_valid, ex_StoreData,
           ex_WriteReg, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
           stall, flush
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, branch flush and
// load-use stall. Load-use detection is built only when LOAD_USE_STALL_EN is defined.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_operand_if.slave  io_ex
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_wreg;
  logic              r_alusrc;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic              r_branch;
  logic [3:0]        r_alu_ctl;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic              w_flush;
  logic              w_stall;
  logic              w_load;

  // EX/MEM is checked first so it always overrides MEM/WB; r0 is never forwarded
  always_comb begin
    w_fwd_rs = r_rd1;
    if (r_rs != '0 && io_ex.mem_RegWrite && io_ex.mem_WriteReg == r_rs)
      w_fwd_rs = io_ex.mem_ALU_result;
    else if (r_rs != '0 && io_ex.wb_RegWrite && io_ex.wb_WriteReg == r_rs)
      w_fwd_rs = io_ex.wb_WriteData;
  end

  always_comb begin
    w_fwd_rt = r_rd2;
    if (r_rt != '0 && io_ex.mem_RegWrite && io_ex.mem_WriteReg == r_rt)
      w_fwd_rt = io_ex.mem_ALU_result;
    else if (r_rt != '0 && io_ex.wb_RegWrite && io_ex.wb_WriteReg == r_rt)
      w_fwd_rt = io_ex.wb_WriteData;
  end

  assign w_flush = r_valid && r_branch && io_ex.ZeroFlag;

`ifdef LOAD_USE_STALL_EN
  assign w_stall = io_ex.id_valid && r_valid && r_memread && (r_wreg != '0) &&
                   ((r_wreg == io_ex.id_Rs) || (r_wreg == io_ex.id_Rt)) && !w_flush;
`else
  assign w_stall = 1'b0;
`endif

  assign w_load = io_ex.id_valid && !w_flush && !w_stall;

  // Anything other than a clean load (flush, stall, empty ID) becomes a full bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wreg     <= '0;
      r_alusrc   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_branch   <= 1'b0;
      r_alu_ctl  <= 4'b0000;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_rd1      <= io_ex.id_ReadData1;
      r_rd2      <= io_ex.id_ReadData2;
      r_imm      <= io_ex.id_Imm;
      r_rs       <= io_ex.id_Rs;
      r_rt       <= io_ex.id_Rt;
      r_wreg     <= io_ex.id_RegDst ? io_ex.id_Rd : io_ex.id_Rt;
      r_alusrc   <= io_ex.id_ALUSrc;
      r_memread  <= io_ex.id_MemRead;
      r_memwrite <= io_ex.id_MemWrite;
      r_regwrite <= io_ex.id_RegWrite;
      r_memtoreg <= io_ex.id_MemtoReg;
      r_branch   <= io_ex.id_Branch;
      r_alu_ctl  <= io_ex.id_ALU_control;
    end else begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wreg     <= '0;
      r_alusrc   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_branch   <= 1'b0;
      r_alu_ctl  <= 4'b0000;
    end
  end

  assign io_ex.ReadData1    = w_fwd_rs;
  assign io_ex.ReadData2    = r_alusrc ? r_imm : w_fwd_rt;
  assign io_ex.ex_StoreData = w_fwd_rt;
  assign io_ex.ALU_control  = r_alu_ctl;
  assign io_ex.ex_valid     = r_valid;
  assign io_ex.ex_WriteReg  = r_wreg;
  assign io_ex.ex_MemRead   = r_memread;
  assign io_ex.ex_MemWrite  = r_memwrite;
  assign io_ex.ex_RegWrite  = r_regwrite;
  assign io_ex.ex_MemtoReg  = r_memtoreg;
  assign io_ex.stall        = w_stall;
  assign io_ex.flush        = w_flush;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed hazard scenarios with literal
// expectations plus randomized traffic compared against an instruction-level model.
module tb_ex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_operand_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .io_ex(bus));

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rd1, rd2, imm;
    logic [AW-1:0] rs, rt, wr;
    logic          alusrc, memread, memwrite, regwrite, memtoreg, branch;
    logic [3:0]    op;
  } instr_t;

  instr_t m;
  int checks = 0;
  int failures = 0;
  logic last_stall = 1'b0;

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] v);
    if (r != 0 && bus.mem_RegWrite && bus.mem_WriteReg == r) return bus.mem_ALU_result;
    if (r != 0 && bus.wb_RegWrite && bus.wb_WriteReg == r) return bus.wb_WriteData;
    return v;
  endfunction

  function automatic logic exp_flush();
    return m.valid && m.branch && bus.ZeroFlag;
  endfunction

  function automatic logic exp_stall();
`ifdef LOAD_USE_STALL_EN
    return bus.id_valid && m.valid && m.memread && m.wr != 0 &&
           (m.wr == bus.id_Rs || m.wr == bus.id_Rt) && !exp_flush();
`else
    return 1'b0;
`endif
  endfunction

  function automatic instr_t next_state();
    instr_t n;
    n = '0;
    if (!exp_flush() && !exp_stall() && bus.id_valid) begin
      n.valid = 1'b1;
      n.rd1 = bus.id_ReadData1; n.rd2 = bus.id_ReadData2; n.imm = bus.id_Imm;
      n.rs = bus.id_Rs; n.rt = bus.id_Rt;
      n.wr = bus.id_RegDst ? bus.id_Rd : bus.id_Rt;
      n.alusrc = bus.id_ALUSrc; n.memread = bus.id_MemRead; n.memwrite = bus.id_MemWrite;
      n.regwrite = bus.id_RegWrite; n.memtoreg = bus.id_MemtoReg; n.branch = bus.id_Branch;
      n.op = bus.id_ALU_control;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ReadData1", bus.ReadData1, fwd(m.rs, m.rd1));
    chk("ReadData2", bus.ReadData2, m.alusrc ? m.imm : fwd(m.rt, m.rd2));
    chk("ex_StoreData", bus.ex_StoreData, fwd(m.rt, m.rd2));
    chk("ALU_control", {28'd0, bus.ALU_control}, {28'd0, m.op});
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m.valid});
    chk("ex_WriteReg", {27'd0, bus.ex_WriteReg}, {27'd0, m.wr});
    chk("ex_ctrl", {28'd0, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_RegWrite, bus.ex_MemtoReg},
        {28'd0, m.memread, m.memwrite, m.regwrite, m.memtoreg});
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall()});
    chk("flush", {31'd0, bus.flush}, {31'd0, exp_flush()});
    last_stall = exp_stall();
  endtask

  task automatic tick();
    instr_t nxt;
    #1;
    check_all();
    nxt = next_state();
    @(posedge clk);
    m = rst_n ? nxt : instr_t'('0);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_ReadData1 = 0; bus.id_ReadData2 = 0; bus.id_Imm = 0;
    bus.id_Rs = 0; bus.id_Rt = 0; bus.id_Rd = 0;
    {bus.id_ALUSrc, bus.id_RegDst, bus.id_MemRead, bus.id_MemWrite,
     bus.id_RegWrite, bus.id_MemtoReg, bus.id_Branch} = 7'b0;
    bus.id_ALU_control = 0;
    bus.mem_RegWrite = 0; bus.mem_WriteReg = 0; bus.mem_ALU_result = 0;
    bus.wb_RegWrite = 0; bus.wb_WriteReg = 0; bus.wb_WriteData = 0;
    bus.ZeroFlag = 0;
  endtask

  // ctl = {ALUSrc, RegDst, MemRead, MemWrite, RegWrite, MemtoReg, Branch}
  task automatic set_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                        input logic [3:0] op, input logic [6:0] ctl);
    bus.id_valid = 1; bus.id_Rs = rs; bus.id_Rt = rt; bus.id_Rd = rd;
    bus.id_ReadData1 = a; bus.id_ReadData2 = b; bus.id_Imm = imm; bus.id_ALU_control = op;
    {bus.id_ALUSrc, bus.id_RegDst, bus.id_MemRead, bus.id_MemWrite,
     bus.id_RegWrite, bus.id_MemtoReg, bus.id_Branch} = ctl;
  endtask

  initial begin
    idle();
    rst_n = 0;
    m = '0;
    @(negedge clk);
    #1;
    chk("reset_ReadData1", bus.ReadData1, 32'h0);
    chk("reset_ex_valid", {31'd0, bus.ex_valid}, 32'h0);
    tick();
    rst_n = 1;

    // forward from MEM beats WB; then WB alone; then registered value
    set_id(5'd3, 5'd0, 5'd7, 32'd5, 32'd0, 32'd0, 4'b0101, 7'b0100100);
    tick();
    idle();
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 3; bus.mem_ALU_result = 32'h77;
    bus.wb_RegWrite = 1; bus.wb_WriteReg = 3; bus.wb_WriteData = 32'h99;
    #1 chk("fwd_mem_priority", bus.ReadData1, 32'h77);
    bus.mem_RegWrite = 0;
    #1 chk("fwd_wb", bus.ReadData1, 32'h99);
    bus.wb_RegWrite = 0;
    #1 chk("fwd_none", bus.ReadData1, 32'h5);
    chk("wr_regdst", {27'd0, bus.ex_WriteReg}, 32'd7);
    tick();

    // register 0 is never forwarded
    set_id(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 4'b0101, 7'b0100100);
    tick();
    idle();
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 0; bus.mem_ALU_result = 32'hFF;
    #1 chk("reg0_no_fwd", bus.ReadData1, 32'h0);
    tick();
    idle();

    // load-use: lw r4 then sub using r4
    set_id(5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 32'd8, 4'b0101, 7'b1010110);
    tick();
    set_id(5'd4, 5'd5, 5'd6, 32'hDEAD, 32'd0, 32'd0, 4'b0110, 7'b0100100);
`ifdef LOAD_USE_STALL_EN
    #1 chk("loaduse_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    #1 chk("loaduse_bubble", {31'd0, bus.ex_valid}, 32'd0);
    chk("loaduse_stall_drop", {31'd0, bus.stall}, 32'd0);
    tick();
`else
    #1 chk("loaduse_nostall", {31'd0, bus.stall}, 32'd0);
    tick();
`endif
    bus.id_valid = 0;
    bus.wb_RegWrite = 1; bus.wb_WriteReg = 4; bus.wb_WriteData = 32'h1234;
    #1 chk("loaduse_wb_fwd", bus.ReadData1, 32'h1234);
    chk("loaduse_sub_op", {28'd0, bus.ALU_control}, 32'd6);
    tick();
    idle();

    // taken branch flushes, not-taken loads
    set_id(5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, 4'b0110, 7'b0000001);
    tick();
    set_id(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 4'b0101, 7'b0100100);
    bus.ZeroFlag = 1;
    #1 chk("branch_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    #1 chk("flush_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_bubble_regwrite", {31'd0, bus.ex_RegWrite}, 32'd0);
    chk("bubble_no_flush", {31'd0, bus.flush}, 32'd0);
    set_id(5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, 4'b0110, 7'b0000001);
    bus.ZeroFlag = 0;
    tick();
    set_id(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 4'b0101, 7'b0100100);
    #1 chk("branch_not_taken", {31'd0, bus.flush}, 32'd0);
    tick();
    #1 chk("nt_loaded_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("nt_loaded_regwrite", {31'd0, bus.ex_RegWrite}, 32'd1);
    idle();
    tick();

    // flush wins over stall
    set_id(5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4, 4'b0101, 7'b1010111);
    tick();
    set_id(5'd2, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 4'b0101, 7'b0100100);
    bus.ZeroFlag = 1;
    #1 chk("fos_flush", {31'd0, bus.flush}, 32'd1);
    chk("fos_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    idle();

    // reset mid-stream
    set_id(5'd1, 5'd0, 5'd2, 32'hAA, 32'd0, 32'd0, 4'b0001, 7'b0100100);
    tick();
    rst_n = 0;
    m = '0;
    #1 chk("midreset_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("midreset_rd1", bus.ReadData1, 32'h0);
    chk("midreset_regwrite", {31'd0, bus.ex_RegWrite}, 32'd0);
    tick();
    rst_n = 1;
    idle();
    set_id(5'd2, 5'd0, 5'd3, 32'h55, 32'd0, 32'd0, 4'b0001, 7'b0100100);
    tick();
    #1 chk("post_reset_load", bus.ReadData1, 32'h55);
    chk("post_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
    idle();
    tick();

    // randomized traffic, ID held while stalled
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 7'($urandom));
        bus.id_valid = ($urandom_range(0, 9) != 0);
      end
      bus.mem_RegWrite = 1'($urandom); bus.mem_WriteReg = 5'($urandom_range(0, 7));
      bus.mem_ALU_result = $urandom;
      bus.wb_RegWrite = 1'($urandom); bus.wb_WriteReg = 5'($urandom_range(0, 7));
      bus.wb_WriteData = $urandom;
      bus.ZeroFlag = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 0;
        m = '0;
      end else begin
        rst_n = 1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage that feeds the ALU in the 5-stage MIPS pipeline. It captures decoded operands and control at the ID→EX boundary and resolves data hazards by forwarding from EX/MEM and MEM/WB. It detects load-use hazards and produces a stall, and turns a taken `beq` (Branch plus ALU `ZeroFlag`) into a flush. Outputs `ReadData1`, `ReadData2` and `ALU_control` drive the ALU directly.

## Interface
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register-index width
- `clk`  in  1  clock; rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_ReadData1`, `id_ReadData2`  in  DATA_W  register-file read data
- `id_Imm`  in  DATA_W  sign-extended immediate
- `id_Rs`, `id_Rt`, `id_Rd`  in  REG_AW  register indices
- `id_ALUSrc`, `id_RegDst`, `id_MemRead`, `id_MemWrite`, `id_RegWrite`, `id_MemtoReg`, `id_Branch`  in  1  decoded control
- `id_ALU_control`  in  4  ALU op (0110 sub, 0011 slt, 0101 add, 0000 and, 0001 or)
- `mem_RegWrite`  in  1, `mem_WriteReg`  in  REG_AW, `mem_ALU_result`  in  DATA_W  EX/MEM forwarding source
- `wb_RegWrite`  in  1, `wb_WriteReg`  in  REG_AW, `wb_WriteData`  in  DATA_W  MEM/WB forwarding source
- `ZeroFlag`  in  1  from ALU, same cycle
- `ReadData1`, `ReadData2`  out  DATA_W  ALU operands
- `ALU_control`  out  4  ALU op
- `ex_valid`  out  1  EX holds a real instruction
- `ex_StoreData`  out  DATA_W  forwarded Rt value for `sw`
- `ex_WriteReg`  out  REG_AW  destination: `RegDst ? Rd : Rt`
- `ex_MemRead`, `ex_MemWrite`, `ex_RegWrite`, `ex_MemtoReg`  out  1  control to EX/MEM
- `stall`  out  1  hold PC and IF/ID
- `flush`  out  1  branch taken; kill IF/ID

## Operation
- **EX register contents:** valid, ReadData1/2, Imm, Rs, Rt, WriteReg, all control bits, and ALU_control.
- **Next-state priority at each edge:**
  - `flush`: load a bubble.
  - Else `stall`: load a bubble; ID is held upstream.
  - Else `id_valid=1`: load ID.
  - Else: load a bubble.
- **Bubble:** valid=0, every control bit 0, ALU_control=0000, Rs/Rt/WriteReg=0, data fields=0.
- **Forwarding** is combinational on the registered EX fields. For source index `r`:
  - If `r≠0 && mem_RegWrite && mem_WriteReg==r`, use `mem_ALU_result`.
  - Else if `r≠0 && wb_RegWrite && wb_WriteReg==r`, use `wb_WriteData`.
  - Else use the registered value.
  - EX/MEM always wins over MEM/WB.
- **Operand outputs:**
  - `ReadData1` = fwd(Rs).
  - `ex_StoreData` = fwd(Rt).
  - `ReadData2` = `ALUSrc ? Imm : fwd(Rt)`.
- **Load-use stall:** `stall = id_valid && ex_valid && ex_MemRead && ex_WriteReg≠0 && (ex_WriteReg==id_Rs || ex_WriteReg==id_Rt) && !flush`.
- **Branch:** `flush = ex_valid && ex_Branch && ZeroFlag`.

## Timing
- **Reset (async, immediate):** EX register holds a bubble. Resulting outputs:
  - `ReadData1=ReadData2=ex_StoreData=0`, `ALU_control=0000`.
  - All ex_* controls 0, `ex_WriteReg=0`, `stall=0`, `flush=0`.
- **Reset mid-operation:** the in-flight instruction is discarded; no partial state survives.
- **Latency:** ID values appear on outputs 1 cycle after capture. Forwarding, stall and flush are combinational, settling in the same cycle.
- **Load-use:** exactly one bubble. The following cycle the load is in MEM and is not forwardable. The dependent instruction reaches EX one cycle later and takes the WB forward.
- **Flush and stall together:** flush wins; stall deasserts.
- **MEM and WB hit the same register:** the MEM value is used.
- **Register 0:** never forwarded, never stalls.
- **Bubble in EX:** no stall or flush regardless of stale `ZeroFlag`.

## Configuration
- `LOAD_USE_STALL_EN` defined: load-use detection as above.
- Undefined: `stall` tied 0 and no bubbles are inserted for load-use; software guarantees a delay slot. Forwarding and flush are unchanged.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream → all outputs 0 and `ex_valid=0` immediately; first ID instruction after release appears on the next edge.
- **Forward from MEM:**
  - Setup: ID `add` Rs=3 with `id_ReadData1=5`; `mem_RegWrite=1`, `mem_WriteReg=3`, `mem_ALU_result=0x77`.
  - Also `wb_RegWrite=1`, `wb_WriteReg=3`, `wb_WriteData=0x99`.
  - Required: `ReadData1=0x77` (MEM has priority over WB).
- **Register 0:** EX Rs=0, `mem_WriteReg=0`, `mem_RegWrite=1`, `mem_ALU_result=0xFF` → `ReadData1` equals the registered value 0.
- **Load-use:**
  - Setup: `lw` to r4 in EX; ID `sub` Rs=4.
  - Required: `stall=1` for one cycle and the next EX is a bubble.
  - Then the `sub` enters EX with `wb_WriteReg=4`, `wb_WriteData=0x1234` → `ReadData1=0x1234`.
- **Taken branch:**
  - Setup: `beq` in EX (`ex_Branch=1`), `ZeroFlag=1`, ID valid.
  - Required: `flush=1`; the next edge loads a bubble (`ex_valid=0`, `ex_RegWrite=0`).
  - Same setup with `ZeroFlag=0`: `flush=0` and the ID instruction is loaded.
- **Flush over stall:** `lw` r2 in EX with `ex_Branch=1`, `ZeroFlag=1`, and ID Rs=2 → `flush=1`, `stall=0`.
